// File: rtl/io_bridge_pkg.sv
// io_bridge_pkg: shared constants and types for the CPU memory-side bridge.
//   IO_BASE       - base of the memory-mapped I/O window (0x30000)
//   IO_PORT_IN    - port select for the RX data port (0x30000)
//   IO_PORT_CLK   - port select for the cycle counter / stop port (0x30004)
//   state_t       - bridge run state (RUN, DRAIN, HALT)
//   src_t         - source of cpu_din for the access registered last cycle
package io_bridge_pkg;

   localparam int MEM_DATA_BUS = 8;
   localparam int BYTE_W       = MEM_DATA_BUS;
   localparam int CPU_ADDR_W   = 32;
   localparam int RAM_ADDR_W   = 17;
   localparam int CNT_W        = 32;

   localparam logic [17:0] IO_BASE     = 18'h30000;
   localparam logic        IO_PORT_IN  = 1'b0;
   localparam logic        IO_PORT_CLK = 1'b1;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   typedef enum logic {
      SRC_RAM = 1'b0,
      SRC_IO  = 1'b1
   } src_t;

   // The I/O window occupies the top quarter of the decoded 256 KB space.
   function automatic logic is_io(input logic [17:0] a);
      return a[17:16] == IO_BASE[17:16];
   endfunction

endpackage

// File: rtl/io_bridge_fifo.sv
// fifo_byte: byte-wide synchronous FIFO, 2^DEPTH_LOG2 entries.
//   clk_in/rst_in  clock, asynchronous active-high reset
//   i_push/i_data  write request; accepted when not full, or when full
//                  and a pop happens in the same cycle
//   i_pop          read request; ignored when empty
//   o_data         current head (valid when ~o_empty)
//   o_full/o_empty occupancy flags
//   o_drop         a push was refused this cycle
module fifo_byte
   import io_bridge_pkg::*;
#(
   parameter int DEPTH_LOG2 = 3
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              i_push,
   input  logic [BYTE_W-1:0] i_data,
   input  logic              i_pop,
   output logic [BYTE_W-1:0] o_data,
   output logic              o_full,
   output logic              o_empty,
   output logic              o_drop
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [BYTE_W-1:0]     r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wptr;
   logic [DEPTH_LOG2-1:0] r_rptr;
   logic [DEPTH_LOG2:0]   r_count;
   logic                  w_push_ok;
   logic                  w_pop_ok;

   // count can only reach DEPTH, so its MSB alone means full
   assign o_empty   = (r_count == '0);
   assign o_full    = r_count[DEPTH_LOG2];
   assign w_pop_ok  = i_pop & ~o_empty;
   assign w_push_ok = i_push & (~o_full | w_pop_ok);
   assign o_drop    = i_push & ~w_push_ok;
   assign o_data    = r_mem[r_rptr];

   always_ff @(posedge clk_in) begin
      if (w_push_ok) r_mem[r_wptr] <= i_data;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push_ok) r_wptr <= r_wptr + 1'b1;
         if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/io_bridge.sv
// io_bridge: decodes CPU byte-bus accesses into RAM or the I/O window,
// serves RX/TX FIFOs and a free-running cycle counter, and generates the
// CPU ready (stall) signal.
//   clk_in, rst_in              clock, asynchronous active-high reset
//   cpu_a/cpu_wr/cpu_dout       CPU address, write flag, write data
//   cpu_din                     read data, one cycle after the address cycle
//   cpu_rdy                     0 stalls the CPU (combinational)
//   ram_a/ram_wr/ram_dout/ram_din  synchronous 128 KB RAM port
//   rx_data/rx_valid            UART receive push
//   tx_data/tx_valid/tx_ready   UART transmit handshake
//   program_stop                sticky: program ended and TX drained
//   rx_overflow                 sticky: an RX byte was dropped
module io_bridge
   import io_bridge_pkg::*;
#(
   parameter int RX_DEPTH_LOG2 = 3,
   parameter int TX_DEPTH_LOG2 = 3
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic [CPU_ADDR_W-1:0] cpu_a,
   input  logic                  cpu_wr,
   input  logic [BYTE_W-1:0]     cpu_dout,
   output logic [BYTE_W-1:0]     cpu_din,
   output logic                  cpu_rdy,
   output logic [RAM_ADDR_W-1:0] ram_a,
   output logic                  ram_wr,
   output logic [BYTE_W-1:0]     ram_dout,
   input  logic [BYTE_W-1:0]     ram_din,
   input  logic [BYTE_W-1:0]     rx_data,
   input  logic                  rx_valid,
   output logic [BYTE_W-1:0]     tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  program_stop,
   output logic                  rx_overflow
);

   state_t            r_state, w_state_nxt;
   src_t              r_src;
   logic [BYTE_W-1:0] r_io_data;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-9:0]  r_latch;
   logic              r_rx_ovf;

   logic              w_io, w_port;
   logic [1:0]        w_byte;
   logic              w_rd_in, w_rd_clk, w_wr_clk, w_tx_need, w_stall;
   logic              w_rx_pop, w_rx_empty, w_rx_full, w_rx_drop;
   logic [BYTE_W-1:0] w_rx_head;
   logic              w_tx_push, w_tx_pop, w_tx_empty, w_tx_full, w_tx_drop;
   logic [BYTE_W-1:0] w_tx_wdata;
   logic              w_unused;

   // Address bits above 17 are not decoded.
   assign w_unused = ^cpu_a[CPU_ADDR_W-1:18] ^ w_rx_full ^ w_tx_drop;

   // ---------------- decode ----------------
   assign w_io      = is_io(cpu_a[17:0]);
   assign w_port    = cpu_a[2];
   assign w_byte    = cpu_a[1:0];
   assign w_rd_in   = w_io & ~cpu_wr & (w_port == IO_PORT_IN);
   assign w_rd_clk  = w_io & ~cpu_wr & (w_port == IO_PORT_CLK);
   assign w_wr_clk  = w_io &  cpu_wr & (w_port == IO_PORT_CLK);
   // A zero byte to the data port is a no-op; the stop port always pushes 0x00.
   assign w_tx_need = w_io & cpu_wr & ((w_port == IO_PORT_CLK) | (cpu_dout != '0));
   assign w_stall   = (w_rd_in & w_rx_empty) | (w_tx_need & w_tx_full);

   // ---------------- RAM path ----------------
   assign ram_a    = cpu_a[RAM_ADDR_W-1:0];
   assign ram_dout = cpu_dout;
   assign ram_wr   = cpu_wr & ~w_io & cpu_rdy;

   // ---------------- FIFOs ----------------
   assign w_rx_pop   = cpu_rdy & w_rd_in;
   assign w_tx_push  = cpu_rdy & w_tx_need;
   assign w_tx_wdata = w_wr_clk ? '0 : cpu_dout;
   assign tx_valid   = ~w_tx_empty;
   assign w_tx_pop   = tx_valid & tx_ready;

   fifo_byte #(.DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .i_push  (rx_valid),
      .i_data  (rx_data),
      .i_pop   (w_rx_pop),
      .o_data  (w_rx_head),
      .o_full  (w_rx_full),
      .o_empty (w_rx_empty),
      .o_drop  (w_rx_drop)
   );

   fifo_byte #(.DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .i_push  (w_tx_push),
      .i_data  (w_tx_wdata),
      .i_pop   (w_tx_pop),
      .o_data  (tx_data),
      .o_full  (w_tx_full),
      .o_empty (w_tx_empty),
      .o_drop  (w_tx_drop)
   );

   // ---------------- FSM ----------------
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) r_state <= ST_RUN;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      cpu_rdy      = 1'b0;
      program_stop = 1'b0;
      case (r_state)
         ST_RUN: begin
            cpu_rdy = ~rst_in & ~w_stall;
            if (cpu_rdy & w_wr_clk) w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (w_tx_empty & ~tx_valid) w_state_nxt = ST_HALT;
         end
         ST_HALT: begin
            program_stop = 1'b1;
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   // ---------------- counter, read path, sticky flags ----------------
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_cnt     <= '0;
         r_latch   <= '0;
         r_src     <= SRC_RAM;
         r_io_data <= '0;
         r_rx_ovf  <= 1'b0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
         if (w_rx_drop) r_rx_ovf <= 1'b1;
         // Stalled accesses leave the read path untouched so a held
         // address replays cleanly once ready rises.
         if (cpu_rdy) begin
            r_src <= (w_io & ~cpu_wr) ? SRC_IO : SRC_RAM;
            if (w_rd_in) r_io_data <= w_rx_head;
            if (w_rd_clk) begin
               // Byte 0 freezes the upper 24 bits so a multi-byte read
               // observes a single counter value.
               case (w_byte)
                  2'd0: begin
                     r_io_data <= r_cnt[7:0];
                     r_latch   <= r_cnt[CNT_W-1:8];
                  end
                  2'd1:    r_io_data <= r_latch[7:0];
                  2'd2:    r_io_data <= r_latch[15:8];
                  default: r_io_data <= r_latch[23:16];
               endcase
            end
         end
      end
   end

   assign rx_overflow = r_rx_ovf;
   assign cpu_din     = rst_in ? '0 : ((r_src == SRC_IO) ? r_io_data : ram_din);

endmodule

// File: tb/tb_io_bridge.sv
module tb_io_bridge;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic [31:0] cpu_a = '0;
   logic        cpu_wr = 1'b0;
   logic [7:0]  cpu_dout = '0;
   logic [7:0]  cpu_din;
   logic        cpu_rdy;
   logic [16:0] ram_a;
   logic        ram_wr;
   logic [7:0]  ram_dout;
   logic [7:0]  ram_din;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic        program_stop;
   logic        rx_overflow;

   io_bridge #(.RX_DEPTH_LOG2(3), .TX_DEPTH_LOG2(3)) dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .cpu_a(cpu_a), .cpu_wr(cpu_wr), .cpu_dout(cpu_dout),
      .cpu_din(cpu_din), .cpu_rdy(cpu_rdy),
      .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .program_stop(program_stop), .rx_overflow(rx_overflow)
   );

   always #5 clk_in = ~clk_in;

   // synchronous RAM behind the bridge
   logic [7:0] mem [0:(1<<17)-1];
   logic [7:0] ram_q;
   always @(posedge clk_in) begin
      if (ram_wr) mem[ram_a] <= ram_dout;
      ram_q <= mem[ram_a];
   end
   assign ram_din = ram_q;

   // reference cycle counter
   logic [31:0] cnt;
   always @(posedge clk_in or posedge rst_in) begin
      if (rst_in) cnt <= '0;
      else        cnt <= cnt + 1;
   end

   int checks = 0;
   int errors = 0;
   int hs_cnt = 0;
   int ram_wr_cnt = 0;
   logic [7:0] exp_rd [$];
   logic [7:0] exp_tx [$];
   logic rd_chk = 1'b0;
   logic pend = 1'b0;
   logic [7:0] e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // read-data monitor: a checked read accepted in cycle N is compared in N+1
   always @(negedge clk_in) begin
      if (pend) begin
         checks++;
         if (exp_rd.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected: got %0h expected none", cpu_din);
         end else begin
            e = exp_rd.pop_front();
            if (cpu_din !== e) begin
               errors++;
               $display("FAIL rd_data: got %0h expected %0h", cpu_din, e);
            end
         end
      end
      pend = rd_chk && !cpu_wr && cpu_rdy && !rst_in;
      if (ram_wr) ram_wr_cnt++;
   end

   // transmit monitor
   always @(negedge clk_in) begin
      if (tx_valid && tx_ready) begin
         hs_cnt++;
         checks++;
         if (exp_tx.size() == 0) begin
            errors++;
            $display("FAIL tx_unexpected: got %0h expected none", tx_data);
         end else if (tx_data !== exp_tx[0]) begin
            errors++;
            $display("FAIL tx_data: got %0h expected %0h", tx_data, exp_tx[0]);
            void'(exp_tx.pop_front());
         end else begin
            void'(exp_tx.pop_front());
         end
      end
   end

   task automatic idle();
      cpu_a = 32'h0; cpu_wr = 1'b0; cpu_dout = 8'h0; rd_chk = 1'b0;
   endtask

   task automatic step();
      @(posedge clk_in); #1;
   endtask

   // one CPU access, held until accepted; called just after a posedge
   task automatic bus(input logic [31:0] a, input logic wr, input logic [7:0] d,
                      input logic chk, input logic [7:0] exp);
      int n;
      cpu_a = a; cpu_wr = wr; cpu_dout = d; rd_chk = chk;
      if (chk) exp_rd.push_back(exp);
      n = 0;
      @(negedge clk_in);
      while (!cpu_rdy && n < 50) begin n++; @(negedge clk_in); end
      if (!cpu_rdy) begin
         checks++; errors++;
         $display("FAIL bus_timeout: addr %0h still stalled, expected ready", a);
      end
      step();
      idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [31:0] snap;
      // ---------------- reset values, write attempted during reset ----------------
      cpu_a = 32'h00300; cpu_wr = 1'b1; cpu_dout = 8'hEE;
      repeat (2) @(negedge clk_in);
      check("rst_rdy", cpu_rdy, 1'b0);
      check("rst_ram_wr", ram_wr, 1'b0);
      check("rst_din", cpu_din, 8'h00);
      check("rst_tx_valid", tx_valid, 1'b0);
      check("rst_stop", program_stop, 1'b0);
      check("rst_ovf", rx_overflow, 1'b0);
      idle();
      step();
      rst_in = 1'b0;
      @(negedge clk_in);
      check("idle_rdy", cpu_rdy, 1'b1);
      step();

      // ---------------- RAM ----------------
      bus(32'h00123, 1'b1, 8'h5A, 1'b0, 8'h00);
      bus(32'h00123, 1'b0, 8'h00, 1'b1, 8'h5A);
      bus(32'h00200, 1'b1, 8'hC3, 1'b0, 8'h00);
      bus(32'h00200, 1'b0, 8'h00, 1'b1, 8'hC3);
      @(negedge clk_in);
      check("ram_wr_pulses", ram_wr_cnt, 2);
      step();

      // ---------------- RX stall ----------------
      cpu_a = 32'h30000; cpu_wr = 1'b0; rd_chk = 1'b1;
      exp_rd.push_back(8'h41);
      repeat (5) begin @(negedge clk_in); check("rx_stall", cpu_rdy, 1'b0); end
      step();
      rx_data = 8'h41; rx_valid = 1'b1;
      @(negedge clk_in); check("rx_push_cycle", cpu_rdy, 1'b0);
      step();
      rx_valid = 1'b0;
      @(negedge clk_in); check("rx_release", cpu_rdy, 1'b1);
      step();
      idle();

      // ---------------- RX overflow, full with simultaneous pop ----------------
      for (int i = 0; i < 8; i++) begin
         rx_data = 8'(8'h10 + i); rx_valid = 1'b1; step();
      end
      rx_valid = 1'b0;
      @(negedge clk_in); check("rx_full_no_ovf", rx_overflow, 1'b0);
      step();
      rx_data = 8'h18; rx_valid = 1'b1; step();
      rx_valid = 1'b0;
      @(negedge clk_in); check("rx_ovf_set", rx_overflow, 1'b1);
      step();
      cpu_a = 32'h30000; rd_chk = 1'b1; exp_rd.push_back(8'h10);
      rx_data = 8'h19; rx_valid = 1'b1;
      @(negedge clk_in); check("rx_full_pop", cpu_rdy, 1'b1);
      step();
      rx_valid = 1'b0; idle();
      for (int i = 1; i < 8; i++) bus(32'h30000, 1'b0, 8'h00, 1'b1, 8'(8'h10 + i));
      bus(32'h30000, 1'b0, 8'h00, 1'b1, 8'h19);
      cpu_a = 32'h30000;
      @(negedge clk_in); check("rx_empty_stall", cpu_rdy, 1'b0);
      step();
      idle();

      // ---------------- TX path ----------------
      tx_ready = 1'b0;
      exp_tx.push_back(8'h48); exp_tx.push_back(8'h49);
      bus(32'h30000, 1'b1, 8'h48, 1'b0, 8'h00);
      bus(32'h30000, 1'b1, 8'h00, 1'b0, 8'h00);
      bus(32'h30000, 1'b1, 8'h49, 1'b0, 8'h00);
      repeat (2) @(negedge clk_in);
      check("tx_head_valid", tx_valid, 1'b1);
      check("tx_head_data", tx_data, 8'h48);
      n = hs_cnt;
      step();
      tx_ready = 1'b1;
      repeat (4) @(negedge clk_in);
      check("tx_count", hs_cnt - n, 2);
      check("tx_empty", tx_valid, 1'b0);
      step();

      // ---------------- TX back-pressure ----------------
      tx_ready = 1'b0;
      for (int i = 0; i < 9; i++) exp_tx.push_back(8'(8'h61 + i));
      for (int i = 0; i < 8; i++) bus(32'h30000, 1'b1, 8'(8'h61 + i), 1'b0, 8'h00);
      cpu_a = 32'h30000; cpu_wr = 1'b1; cpu_dout = 8'h69;
      repeat (3) begin @(negedge clk_in); check("tx_full_stall", cpu_rdy, 1'b0); end
      step();
      tx_ready = 1'b1;
      @(negedge clk_in); check("tx_full_pop_cycle", cpu_rdy, 1'b0);
      step();
      tx_ready = 1'b0;
      @(negedge clk_in); check("tx_full_release", cpu_rdy, 1'b1);
      step();
      idle(); tx_ready = 1'b1;
      repeat (12) @(negedge clk_in);
      check("tx_drained", tx_valid, 1'b0);
      step();

      // ---------------- reset mid-run, counter snapshot ----------------
      rst_in = 1'b1;
      @(negedge clk_in); check("rst2_rdy", cpu_rdy, 1'b0);
      step();
      rst_in = 1'b0;
      n = 0;
      while (cnt != 32'hFF && n < 1000) begin step(); n++; end
      check("cnt_reach", cnt, 32'hFF);
      bus(32'h30004, 1'b0, 8'h00, 1'b1, 8'hFF);
      repeat (3) step();
      bus(32'h30005, 1'b0, 8'h00, 1'b1, 8'h00);
      repeat (3) step();
      bus(32'h30006, 1'b0, 8'h00, 1'b1, 8'h00);
      repeat (3) step();
      bus(32'h30007, 1'b0, 8'h00, 1'b1, 8'h00);
      step();
      snap = cnt;
      bus(32'h30004, 1'b0, 8'h00, 1'b1, snap[7:0]);
      repeat (2) step();
      bus(32'h30005, 1'b0, 8'h00, 1'b1, snap[15:8]);
      step();

      // ---------------- program stop ----------------
      tx_ready = 1'b0;
      exp_tx.push_back(8'h31); exp_tx.push_back(8'h32); exp_tx.push_back(8'h00);
      bus(32'h30000, 1'b1, 8'h31, 1'b0, 8'h00);
      bus(32'h30000, 1'b1, 8'h32, 1'b0, 8'h00);
      cpu_a = 32'h30004; cpu_wr = 1'b1; cpu_dout = 8'h77; tx_ready = 1'b1;
      @(negedge clk_in); check("stop_accept", cpu_rdy, 1'b1);
      step();
      idle();
      @(negedge clk_in); check("drain_stall", cpu_rdy, 1'b0);
      n = 0;
      do begin @(negedge clk_in); n++; end
      while (!(tx_valid && tx_ready && tx_data == 8'h00) && n < 20);
      check("stop_last_hs", {tx_valid, tx_data}, {1'b1, 8'h00});
      check("stop_not_yet", program_stop, 1'b0);
      n = 0;
      while (!program_stop && n < 10) begin @(negedge clk_in); n++; end
      check("stop_rise", program_stop, 1'b1);
      repeat (4) begin
         @(negedge clk_in);
         check("halt_rdy", cpu_rdy, 1'b0);
         check("halt_sticky", program_stop, 1'b1);
      end
      step();

      // ---------------- reset clears halt ----------------
      rst_in = 1'b1; step(); rst_in = 1'b0;
      @(negedge clk_in);
      check("rst3_stop", program_stop, 1'b0);
      check("rst3_rdy", cpu_rdy, 1'b1);
      check("rst3_ovf", rx_overflow, 1'b0);
      check("exp_rd_empty", exp_rd.size(), 0);
      check("exp_tx_empty", exp_tx.size(), 0);
      check("ram_wr_total", ram_wr_cnt, 2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
